rvx_mc_alu: RTL

- Parametrised, multi-cycle successor to the single-cycle RVX10 ALU.
- Accepts one operation at a time through a valid/ready handshake and returns the result through a held valid/ready output.
- Logic, arithmetic and min/max ops finish in one cycle. Shifts and rotates run iteratively, SHIFT_STEP bits per cycle. A new MUL op (low XLEN bits of the product) runs as a shift-add, MUL_STEP multiplier bits per cycle.
- Sits between the decode stage and writeback of the upcoming multi-cycle core.

---
 rtl/rvx_mc_alu_pkg.sv | 30 +++
 rtl/rvx_alu_comb.sv | 50 +++++
 rtl/rvx_mc_alu.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rvx_mc_alu_pkg.sv
// ============================================================================
// rvx_pkg: op codes, FSM states and op classification for the RVX10 multi-cycle ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

package rvx_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_XOR  = 5'd4,  OP_SLT  = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7,
        OP_ANDN = 5'd8,  OP_ORN  = 5'd9,  OP_XNOR = 5'd10, OP_MIN  = 5'd11,
        OP_MAX  = 5'd12, OP_MINU = 5'd13, OP_MAXU = 5'd14, OP_ROL  = 5'd15,
        OP_ROR  = 5'd16, OP_ABS  = 5'd17, OP_MUL  = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_iterative(input logic [4:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_ROL) ||
               (op == OP_ROR) || (op == OP_MUL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rvx_alu_comb.sv
// ============================================================================
// rvx_alu_comb: single-cycle ALU ops; anything it does not implement is flagged illegal
// Revision: 1.0
// ============================================================================
`default_nettype none

module rvx_alu_comb
    import rvx_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            OP_ANDN: result = a & ~b;
            OP_ORN:  result = a | ~b;
            OP_XNOR: result = ~(a ^ b);
            OP_MIN:  result = lt_s ? a : b;
            OP_MAX:  result = lt_s ? b : a;
            OP_MINU: result = lt_u ? a : b;
            OP_MAXU: result = lt_u ? b : a;
            // Negating the most negative value wraps back to itself.
            OP_ABS:  result = a[XLEN-1] ? (~a + 1'b1) : a;
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rvx_mc_alu.sv
// ============================================================================
// rvx_mc_alu: multi-cycle ALU with iterative shifts/rotates and shift-add multiply
// Revision: 1.0
// ============================================================================
`default_nettype none

module rvx_mc_alu
    import rvx_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4,
    parameter int MUL_STEP   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_illegal,
    output logic            busy
);

    localparam int               SW        = $clog2(XLEN);
    localparam int               ITERS     = XLEN / MUL_STEP;
    localparam int               CW        = $clog2(ITERS) + 1;
    localparam logic [SW:0]      STEP_MAX  = (SW+1)'(SHIFT_STEP);
    localparam logic [SW:0]      XLEN_W    = (SW+1)'(XLEN);
    localparam logic [CW-1:0]    LAST_ITER = CW'(ITERS - 1);

    state_e          state;
    alu_op_e         op_q;
    logic [XLEN-1:0] work;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [SW-1:0]   remaining;
    logic [CW-1:0]   cnt;

    logic [XLEN-1:0] comb_result;
    logic            comb_illegal;
    logic [SW-1:0]   shamt;
    logic [SW-1:0]   step;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] acc_next;
    logic [XLEN-1:0] single_result;

    rvx_alu_comb #(.XLEN(XLEN)) u_comb (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .result  (comb_result),
        .illegal (comb_illegal)
    );

    assign shamt         = in_b[SW-1:0];
    // A shift or rotate by zero completes immediately with operand A.
    assign single_result = is_iterative(in_op) ? in_a : comb_result;
    assign step          = ({1'b0, remaining} > STEP_MAX) ? STEP_MAX[SW-1:0] : remaining;
    assign acc_next      = acc + work * XLEN'(mplier[MUL_STEP-1:0]);

    always_comb begin
        shifted = work;
        case (op_q)
            OP_SLL:  shifted = work << step;
            OP_SRL:  shifted = work >> step;
            OP_ROL:  shifted = (work << step) | (work >> (XLEN_W - {1'b0, step}));
            OP_ROR:  shifted = (work >> step) | (work << (XLEN_W - {1'b0, step}));
            default: shifted = work;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            work        <= '0;
            mplier      <= '0;
            acc         <= '0;
            remaining   <= '0;
            cnt         <= '0;
            out_result  <= '0;
            out_zero    <= 1'b1;
            out_illegal <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= alu_op_e'(in_op);
                    if (in_op == OP_MUL) begin
                        work   <= in_a;
                        mplier <= in_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else if (is_iterative(in_op) && (shamt != '0)) begin
                        work      <= in_a;
                        remaining <= shamt;
                        state     <= RUN;
                    end else begin
                        out_result  <= single_result;
                        out_zero    <= (single_result == '0);
                        out_illegal <= comb_illegal & ~is_iterative(in_op);
                        state       <= DONE;
                    end
                end
                RUN: if (op_q == OP_MUL) begin
                    acc    <= acc_next;
                    work   <= work << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        out_result  <= acc_next;
                        out_zero    <= (acc_next == '0);
                        out_illegal <= 1'b0;
                        state       <= DONE;
                    end
                end else begin
                    work      <= shifted;
                    remaining <= remaining - step;
                    if (remaining == step) begin
                        out_result  <= shifted;
                        out_zero    <= (shifted == '0);
                        out_illegal <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) & ~flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

`default_nettype wire
